// File: rtl/gon_multicast_source_pkg.sv
// Shared definitions for the GON multicast source.
// Holds the controller state encoding and the default tag/id and payload
// widths used by gon_multicast_source and its FIFO.
package gon_multicast_source_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONFIG = 2'd1,
        ST_RUN    = 2'd2
    } gon_state_t;

    localparam int GON_ID_LEN    = 4;
    localparam int GON_VALUE_LEN = 32;

endpackage

// File: rtl/gon_multicast_source_fifo.sv
// gon_source_fifo: outgoing buffer of the GON multicast source.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push_valid/ready    producer handshake, push_data written on acceptance
//   pop                 request to drop the head (ignored when empty)
//   head                entry at the read pointer
//   empty, full         occupancy flags
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module gon_source_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));
    // A pop in the same cycle does not free a slot for this cycle's push.
    assign push_ready = !full;
    assign do_push    = push_valid & push_ready;
    assign do_pop     = pop & !empty;
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gon_multicast_source.sv
// gon_multicast_source: programs the id scan chain of the GON controllers,
// then multicasts buffered (tag, value) words on the GON bus.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cfg_start, cfg_valid/ready,   host id programming stream,
//   cfg_id, cfg_done              cfg_done pulses once the chain is loaded
//   set_id, id_out                scan chain drive
//   in_valid/ready, in_tag,       producer stream into the FIFO
//   in_value
//   tag, enable, value, ready     GON bus (ready = OR of controller ready_out)
//   busy                          programming or data pending
// Optional macro GON_SOURCE_PERF_EN adds perf_xfers / perf_stalls
// saturating counters of completed and stalled bus cycles.
//
// state  | meaning
// IDLE   | waiting for cfg_start
// CONFIG | shifting CHAIN_LEN ids into the scan chain
// RUN    | draining the FIFO onto the GON bus
module gon_multicast_source
    import gon_multicast_source_pkg::*;
#(
    parameter int ID_LEN     = GON_ID_LEN,
    parameter int VALUE_LEN  = GON_VALUE_LEN,
    parameter int FIFO_DEPTH = 4,
    parameter int CHAIN_LEN  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [ID_LEN-1:0]    cfg_id,
    output logic                 cfg_done,
    output logic                 set_id,
    output logic [ID_LEN-1:0]    id_out,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ID_LEN-1:0]    in_tag,
    input  logic [VALUE_LEN-1:0] in_value,
    output logic [ID_LEN-1:0]    tag,
    output logic                 enable,
    output logic [VALUE_LEN-1:0] value,
    input  logic                 ready,
    output logic                 busy
`ifdef GON_SOURCE_PERF_EN
    ,
    output logic [31:0]          perf_xfers,
    output logic [31:0]          perf_stalls
`endif
);

    localparam int SLOT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int ENTRY_W = ID_LEN + VALUE_LEN;

    gon_state_t          state;
    logic [SLOT_W-1:0]   slot_cnt;
    logic [ENTRY_W-1:0]  head;
    logic                fifo_empty;
    logic                fifo_full;
    logic                fifo_pop;

    gon_source_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  ({in_tag, in_value}),
        .pop        (fifo_pop),
        .head       (head),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    // Gating with rst keeps a reset during programming from emitting one
    // last shift into the chain while the state register is still CONFIG.
    assign cfg_ready = (state == ST_CONFIG) & !rst;
    assign set_id    = cfg_ready & cfg_valid;
    assign id_out    = set_id ? cfg_id : '0;

    assign enable    = (state == ST_RUN) & !fifo_empty;
    assign fifo_pop  = enable & ready;
    assign tag       = fifo_empty ? '0 : head[ENTRY_W-1 -: ID_LEN];
    assign value     = enable ? head[VALUE_LEN-1:0] : '0;
    assign busy      = (state == ST_CONFIG) | !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            slot_cnt <= '0;
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        state    <= ST_CONFIG;
                        slot_cnt <= '0;
                    end
                end
                ST_CONFIG: begin
                    if (cfg_valid) begin
                        if (slot_cnt == SLOT_W'(CHAIN_LEN - 1)) begin
                            state    <= ST_RUN;
                            cfg_done <= 1'b1;
                            slot_cnt <= '0;
                        end else begin
                            slot_cnt <= slot_cnt + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // Reprogramming only once nothing is left to deliver.
                    if (cfg_start && fifo_empty) begin
                        state    <= ST_CONFIG;
                        slot_cnt <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef GON_SOURCE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_xfers  <= '0;
            perf_stalls <= '0;
        end else begin
            if (enable && ready && perf_xfers != '1)
                perf_xfers <= perf_xfers + 1'b1;
            if (enable && !ready && perf_stalls != '1)
                perf_stalls <= perf_stalls + 1'b1;
        end
    end
`else
    // Performance counters not built.
`endif

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: doc/gon_multicast_source.md
GON_MULTICAST_SOURCE -- requirements
Module: gon_multicast_source

Interface
REQ-001 SHALL have parameter ID_LEN, default 4, width of tag and id words.
REQ-002 SHALL have parameter VALUE_LEN, default 32, width of the payload.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, entries in the outgoing buffer (power of two, >=2).
REQ-004 SHALL have parameter CHAIN_LEN, default 8, number of controllers on the driven id scan chain.
REQ-005 SHALL have ports: clk in 1, the single clock; rst in 1, reset, synchronous, active-high.
REQ-006 SHALL have ports: cfg_start in 1, request id programming; cfg_valid in 1 / cfg_ready out 1 / cfg_id in ID_LEN, the host id stream; cfg_done out 1, one-cycle pulse when programming completes.
REQ-007 SHALL have ports: set_id out 1 / id_out out ID_LEN, drive the scan chain (set_id shifts every controller by one).
REQ-008 SHALL have ports: in_valid in 1 / in_ready out 1 / in_tag in ID_LEN / in_value in VALUE_LEN, the producer stream.
REQ-009 SHALL have ports: tag out ID_LEN / enable out 1 / value out VALUE_LEN / ready in 1, the GON bus, where ready is the OR of the controllers' ready_out.
REQ-010 SHALL have port: busy out 1, high in CONFIG or when the FIFO is non-empty.

Function
REQ-011 SHALL implement states IDLE, CONFIG, RUN; reset enters IDLE.
REQ-012 IDLE: cfg_start -> CONFIG; otherwise it SHALL stay in IDLE.
REQ-013 CONFIG: cfg_ready=1; each cfg_valid cycle SHALL assert set_id with id_out=cfg_id the same cycle (combinational pass-through) and increment a slot counter.
REQ-014 CONFIG: the CHAIN_LEN-th accepted id SHALL cause a transition to RUN next cycle and pulse cfg_done in that cycle; the first accepted id ends in the farthest controller.
REQ-015 Outside CONFIG, set_id=0, id_out=0, cfg_ready=0.
REQ-016 RUN: cfg_start with the FIFO empty SHALL re-enter CONFIG (counter cleared); with the FIFO non-empty cfg_start SHALL be ignored.
REQ-017 in_ready SHALL equal !full in every state; push on in_valid&in_ready.
REQ-018 Push to an empty FIFO SHALL NOT bypass: the earliest enable is the next cycle (1-cycle latency).
REQ-019 enable SHALL equal (state==RUN) & !empty; tag=head tag when non-empty else 0; value=head value when enable else 0.
REQ-020 A transfer SHALL complete on enable&ready, popping the head; tag and value SHALL be held stable while enable=1 and ready=0.
REQ-021 Simultaneous push and pop SHALL keep the count unchanged; when full, a same-cycle pop SHALL NOT raise in_ready that cycle.
REQ-022 Pointers SHALL wrap modulo FIFO_DEPTH; count width SHALL be $clog2(FIFO_DEPTH)+1.

Reset
REQ-023 rst SHALL clear state to IDLE, empty the FIFO, and clear the slot counter.
REQ-024 After reset: in_ready=1, enable=0, tag=0, value=0, set_id=0, id_out=0, cfg_ready=0, cfg_done=0, busy=0.
REQ-025 rst mid-CONFIG or mid-transfer SHALL discard all pending data and partial programming without any further set_id pulse.

Configuration
REQ-026 When macro GON_SOURCE_PERF_EN is defined, it SHALL add outputs perf_xfers (32) and perf_stalls (32): xfers counts enable&ready cycles, stalls counts enable&!ready cycles; both saturate at all-ones and clear on rst.
REQ-027 Without GON_SOURCE_PERF_EN, those ports and counters SHALL be absent and function SHALL be otherwise identical.

Structure
REQ-028 The shared gon package SHALL hold the state encoding (IDLE=0, CONFIG=1, RUN=2) and the default ID_LEN and VALUE_LEN constants.
REQ-029 The FIFO SHALL be one sub-module, gon_source_fifo (parameters width and depth, valid/ready push, pop on enable&ready).

Verification
REQ-030 Reset, cfg_start, then 8 ids 0..7 with cfg_valid continuous: 8 set_id pulses with id_out=0..7, cfg_done on the cycle after the 8th, then state RUN.
REQ-031 RUN: push (tag=3, value=0xDEADBEEF) with ready tied to (tag==3): enable rises 1 cycle after the push, then 1 transfer, then enable=0 and value=0.
REQ-032 ready held 0 for 5 cycles with a head of (tag=5, value=0x1234): tag and value stay stable, perf_stalls=5 (macro on), then on ready=1 a pop occurs.
REQ-033 Push 4 entries with ready=0: in_ready=0 after the 4th; a 5th in_valid is not accepted; releasing ready drains all 4 in order.
REQ-034 RUN with 2 entries queued, cfg_start asserted: ignored, state stays RUN; after the drain, cfg_start enters CONFIG.
REQ-035 rst asserted after 3 of 8 config ids: state IDLE, no further set_id, and all outputs at their reset values.
